// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch-stage state encoding, reset PC default,
// word size and the major opcodes the decoder also keys on.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: synchronous FIFO of {inst, pc} entries with push/pop/flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  // a full buffer still takes a push when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, fetch buffer,
// redirect handling. Define IF_MISALIGN_CHK_EN to trap misaligned redirects.
module if_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2,
  localparam int         CW        = $clog2(BUF_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ifl_q, ifl_d;
  logic          req_q;
  logic          fault_q;
  logic          misalign;
  logic [31:0]   tgt;
  logic          push, pop, flush;
  logic          buf_full, buf_empty;
  logic [CW-1:0] buf_count;
  fetch_entry_t  buf_head, buf_din;
  int            occ;

`ifdef IF_MISALIGN_CHK_EN
  assign misalign = |redirect_pc[1:0];
  assign tgt      = redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_q | (redirect_valid & misalign);
  end
`else
  assign misalign = 1'b0;
  assign tgt      = word_align(redirect_pc);
  assign fault_q  = 1'b0;
`endif

  assign pop         = inst_valid & inst_ready;
  assign buf_din     = '{inst: imem_rdata, pc: ifl_q};
  assign inst_valid  = ~buf_empty;
  assign inst        = buf_head.inst;
  assign inst_pc     = buf_head.pc;
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign fetch_fault = fault_q;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (buf_din),
    .pop   (pop),
    .flush (flush),
    .head  (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifl_d   = ifl_q;
    push    = 1'b0;
    flush   = 1'b0;
    // occupancy once this cycle's pop has left
    occ     = int'(buf_count) - (pop ? 1 : 0);
    if (fault_q) begin
      state_d = ST_HOLD;
    end else if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = tgt;
      if (misalign) begin
        state_d = ST_HOLD;
      end else begin
        case (state_q)
          ST_HOLD: state_d = ST_REQ;
          ST_REQ:  state_d = imem_gnt ? ST_KILL : ST_REQ;
          // an in-flight response must drain before refetching
          ST_WAIT,
          ST_KILL: state_d = imem_rvalid ? ST_REQ : ST_KILL;
          default: state_d = ST_HOLD;
        endcase
      end
    end else begin
      case (state_q)
        ST_HOLD: if (!buf_full) state_d = ST_REQ;
        ST_REQ: begin
          if (imem_gnt) begin
            pc_d    = pc_q + WORD_BYTES;
            ifl_d   = pc_q;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = (occ + 1 < BUF_DEPTH) ? ST_REQ : ST_HOLD;
          end
        end
        ST_KILL: begin
          if (imem_rvalid) state_d = (occ < BUF_DEPTH) ? ST_REQ : ST_HOLD;
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      pc_q    <= RESET_PC;
      ifl_q   <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifl_q   <= ifl_d;
      req_q   <= (state_d == ST_REQ);
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the RISC-V core, directly upstream of the decoder. Keeps the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small FIFO. Presents `{inst, inst_pc}` to the decoder with a valid/ready handshake, and restarts on branch/jump redirects (BEQ/BLT/BGE/JAL) resolved downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: fetch-buffer entries, power of two, ≥2.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  32  word-aligned fetch address, registered.
- `imem_gnt`  in  1  memory accepts the request this cycle (only meaningful with `imem_req`).
- `imem_rvalid`  in  1  read data valid; in order, ≥1 cycle after grant.
- `imem_rdata`  in  32  fetched instruction word.
- `redirect_valid`  in  1  one-cycle pulse, PC redirect.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  buffer head valid.
- `inst`  out  32  buffer head instruction.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  decoder consumes head when `inst_valid & inst_ready`.
- `fetch_fault`  out  1  misaligned redirect detected (see Configuration).

## Operation
- At most one outstanding memory request. Memory samples `imem_addr` only on granted cycles; address may change while ungranted.
- States: HOLD, REQ, WAIT, KILL. Reset state HOLD.
  - HOLD: `imem_req`=0. → REQ when buffer occupancy < BUF_DEPTH.
  - REQ: `imem_req`=1, `imem_addr`=pc. On gnt: pc ← pc+4, → WAIT.
  - WAIT: on rvalid: push `{imem_rdata, fetch address}`; → REQ if post-push occupancy (including same-cycle pop) < BUF_DEPTH, else HOLD.
  - KILL: in-flight response is stale; on rvalid, drop it, → REQ (or HOLD per occupancy).
- Redirect (highest priority): buffer flushed; pc ← redirect_pc.
  - REQ without gnt: → REQ, address switches next cycle.
  - REQ with gnt same cycle, or WAIT without rvalid: → KILL.
  - WAIT with rvalid same cycle: response dropped, → REQ.
  - KILL: stays KILL with new pc; HOLD: → REQ.
- Redirect with same-cycle pop: pop completes (decoder owns that instruction), then flush.
- pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 → 0.
- Push and pop in the same cycle: occupancy unchanged; full buffer still accepts pop.
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fetch_fault`=0, pc=RESET_PC, occupancy 0.
- Reset mid-operation: all state cleared asynchronously; any later `imem_rvalid` before the first new grant is ignored.

## Timing
- First request: cycle after the first rising edge with `rst` low.
- Grant → rvalid ≥1 cycle; rvalid → `inst_valid` on the next cycle (no bypass).
- Peak throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect at edge N: `inst_valid`=0 after edge N; request to target at earliest after edge N (REQ/HOLD/WAIT+rvalid cases).
- Outputs `inst`, `inst_pc` stable while `inst_valid & ~inst_ready`.

## Configuration
- `IF_MISALIGN_CHK_EN` defined: redirect with `redirect_pc[1:0]` ≠ 0 sets `fetch_fault` (sticky until reset), flushes buffer, enters HOLD permanently; outstanding response discarded.
- Undefined: `redirect_pc[1:0]` ignored (forced to 00); `fetch_fault` tied 0.

## Structure
- Shared package `riscv_pkg`: fetch-state enum, `RESET_PC` default, word size constant 4, opcode constants shared with the decoder.
- One sub-module: `fetch_buf`, synchronous FIFO (BUF_DEPTH × 64 bits, push/pop/flush, full/empty, occupancy).

## Test plan
- Reset release, 1-cycle memory returning 32'h00000013 per address, `inst_ready`=1 → `inst_pc` sequence 0,4,8,…; one instruction per 2 cycles.
- `inst_ready`=0 → after two pushes (BUF_DEPTH=2) `imem_req` drops, `inst_pc`=0 held; raising `inst_ready` resumes at address 8.
- Redirect to 32'h0000_0100 in WAIT, stale rvalid 3 cycles later → stale word never visible; next `inst_pc`=32'h100.
- Redirect coincident with rvalid and with a pop → popped instruction consumed, returned word dropped, next fetch 32'h100.
- pc reaching 32'hFFFF_FFFC → next `imem_addr`=0.
- With `IF_MISALIGN_CHK_EN`: redirect to 32'h0000_0102 → `fetch_fault`=1, `imem_req` stays 0 until reset.
